// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : seven-segment pattern constants and scan defaults           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int NUM_DIGITS       = 8;
  localparam int SCAN_DIV_DEFAULT = 50000;

  // Active-high a..g patterns, bit 0 = segment a
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decode : BCD nibble to active-high a..g pattern, dash if invalid |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_display : 8-digit multiplexed 7-seg driver, per-frame latch  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bcd_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      frame;
  logic             tick;
  logic [3:0]       digit;
  logic [6:0]       pattern;
  logic [31:0]      lz_mask;
  logic             blank;
  logic [7:0]       an_next;
  logic [7:0]       seg_next;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 1'b1;
        // Snapshot only at the wrap so a frame never mixes two scores
        if (idx == IDX_LAST) begin
          frame      <= bcd_in;
          frame_tick <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign digit = frame[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble  (digit),
    .pattern (pattern)
  );

  // Digit is a leading zero when it and every higher nibble are zero
  assign lz_mask = 32'hFFFF_FFFF << {idx, 2'b00};
  assign blank   = blank_lz && (idx != '0) && ((frame & lz_mask) == 32'h0);

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 8'hFF;
    if (!blank) begin
      an_next  = ~(8'b1 << idx);
      seg_next = {1'b1, ~pattern};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule : seg_scan_display
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_display : scoreboard bench for seg_scan_display           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seg_scan_display;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bcd = 32'h0;
  logic        blank = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  int          m_cyc = 0;
  logic [31:0] m_frame = 32'h0;
  logic [16:0] sb[$];

  seg_scan_display #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd),
    .blank_lz   (blank),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, m_cyc, got, exp);
    end
  endtask

  // One clock: predict outputs after the coming edge, then compare at edge+1
  task automatic step();
    int          n;
    int          ix;
    logic [3:0]  d;
    logic [7:0]  ea;
    logic [7:0]  es;
    logic        ef;
    logic [7:0]  one;
    logic [16:0] got;
    n   = m_cyc + 1;
    ix  = (m_cyc / SD) % 8;
    d   = m_frame[4*ix +: 4];
    one = 8'b1;
    if (blank && ix != 0 && (m_frame >> (4*ix)) == 32'h0) begin
      ea = 8'hFF;
      es = 8'hFF;
    end else begin
      ea = ~(one << ix);
      es = exp_seg(d);
    end
    ef = (n % FRAME == 0);
    sb.push_back({ea, es, ef});
    @(posedge clk);
    if (n % FRAME == 0) m_frame = bcd;
    m_cyc = n;
    #1;
    got = sb.pop_front();
    chk("an", an, got[16:9]);
    chk("seg", seg, got[8:1]);
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, got[0]});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ft", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    bcd   = 32'h0000_2048;
    blank = 1'b0;
    rst_n = 1'b1;

    // First frame shows 0, snapshot at edge 32, then 2048 unblanked
    run(2 * FRAME);
    // Blank leading zeros on the already captured frame
    blank = 1'b1;
    run(FRAME);

    // Zero value with blanking: only digit 0 lit
    bcd = 32'h0;
    run(2 * FRAME);

    // Overflow dash on top digit, zeros between are not leading
    bcd = 32'hA000_0001;
    run(2 * FRAME);

    // bcd changes every cycle; only the wrap-edge value may be shown
    blank = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      bcd = $urandom;
      step();
    end
    blank = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      bcd = $urandom;
      step();
    end

    // Async reset in the middle of digit 5
    blank = 1'b0;
    bcd   = 32'h8765_4321;
    while ((m_cyc % FRAME) != 5 * SD + 2) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_seg", seg, 8'hFF);
    chk("async_ft", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_an", an, 8'hFF);
    rst_n   = 1'b1;
    m_cyc   = 0;
    m_frame = 32'h0;
    sb.delete();
    run(FRAME + 2 * SD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg_scan_display
`default_nettype wire
